// File: rtl/interleaver_sequencer_if.sv
// Handshake and interleaver-side signals of the interleaver sequencer.
// master: the sequencer itself; slave: the environment around it.
interface interleaver_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] il_data_in;
  logic              il_enable;
  logic [DATA_W-1:0] il_data_out;
  logic [DATA_W-1:0] m_sys;
  logic [DATA_W-1:0] m_int;
  logic              m_valid;
  logic              m_ready;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;

  modport master (
    input  s_data, s_valid, il_enable, il_data_out, m_ready, err_clr,
    output s_ready, il_data_in, m_sys, m_int, m_valid, busy, timeout_err
  );

  modport slave (
    output s_data, s_valid, il_enable, il_data_out, m_ready, err_clr,
    input  s_ready, il_data_in, m_sys, m_int, m_valid, busy, timeout_err
  );
endinterface

// File: rtl/interleaver_sequencer.sv
// Sequences the LFSR pairwise-swap interleaver: one systematic byte at a time,
// forcing an input change (kick) on first/repeated bytes, then emitting the
// {systematic, interleaved} pair. Wait phases are guarded by a timeout.
module interleaver_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  interleaver_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT_START,
    S_WAIT_DONE,
    S_OUT
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_last_byte;
  logic              r_first;
  logic [CNT_W-1:0]  r_timer;
  logic [DATA_W-1:0] r_il_data_in;
  logic [DATA_W-1:0] r_m_sys;
  logic [DATA_W-1:0] r_m_int;
  logic              r_m_valid;
  logic              r_timeout_err;

  logic              w_timer_end;
  logic              w_needs_kick;

  assign w_timer_end  = (r_timer == TMO_LAST);
  assign w_needs_kick = r_first || (bus.s_data == r_last_byte);

  assign bus.s_ready     = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.il_data_in  = r_il_data_in;
  assign bus.m_sys       = r_m_sys;
  assign bus.m_int       = r_m_int;
  assign bus.m_valid     = r_m_valid;
  assign bus.timeout_err = r_timeout_err;

  // Sequencer FSM with registered outputs; a timeout set overrides err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cur         <= '0;
      r_last_byte   <= '0;
      r_first       <= 1'b1;
      r_timer       <= '0;
      r_il_data_in  <= '0;
      r_m_sys       <= '0;
      r_m_int       <= '0;
      r_m_valid     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.s_valid) begin
            r_cur   <= bus.s_data;
            r_timer <= '0;
            if (w_needs_kick) begin
              r_il_data_in <= ~bus.s_data;
              r_state      <= S_KICK;
            end else begin
              r_il_data_in <= bus.s_data;
              r_state      <= S_WAIT_START;
            end
          end
        end

        S_KICK: begin
          r_il_data_in <= r_cur;
          r_state      <= S_WAIT_START;
        end

        S_WAIT_START: begin
          if (!bus.il_enable) begin
            r_timer <= r_timer + CNT_W'(1);
            r_state <= S_WAIT_DONE;
          end else if (w_timer_end) begin
            r_timeout_err <= 1'b1;
            r_first       <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_WAIT_DONE: begin
          if (bus.il_enable) begin
            r_m_sys     <= r_cur;
            r_m_int     <= bus.il_data_out;
            r_m_valid   <= 1'b1;
            r_last_byte <= r_cur;
            r_first     <= 1'b0;
            r_state     <= S_OUT;
          end else if (w_timer_end) begin
            r_timeout_err <= 1'b1;
            r_first       <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end

        S_OUT: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_sequencer.sv
// Directed bench for interleaver_sequencer with a behavioural interleaver:
// any change on il_data_in drops il_enable, and after a fixed latency the
// pairwise bit swap of the current input appears with il_enable high.
module tb_interleaver_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  bit       stuck_en = 1'b0;
  logic [7:0] il_prev;
  int       il_cnt;

  interleaver_sequencer_if #(.DATA_W(8)) sif ();

  interleaver_sequencer #(
    .DATA_W (8),
    .TIMEOUT(64),
    .CNT_W  (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pswap(input logic [7:0] d);
    return {d[6], d[7], d[4], d[5], d[2], d[3], d[0], d[1]};
  endfunction

  // Interleaver model: restart on input change, result after 5 quiet cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      il_prev         <= 8'h00;
      il_cnt          <= 0;
      sif.il_enable   <= 1'b1;
      sif.il_data_out <= 8'h00;
    end else begin
      il_prev <= sif.il_data_in;
      if (stuck_en) begin
        sif.il_enable <= 1'b1;
      end else if (sif.il_data_in != il_prev) begin
        sif.il_enable <= 1'b0;
        il_cnt        <= 5;
      end else if (!sif.il_enable) begin
        if (il_cnt == 0) begin
          sif.il_data_out <= pswap(sif.il_data_in);
          sif.il_enable   <= 1'b1;
        end else begin
          il_cnt <= il_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_mvalid(input string tag);
    for (int i = 0; i < 100 && !sif.m_valid; i++) tick();
    chk1({tag, "_mvalid"}, sif.m_valid, 1'b1);
  endtask

  // Accept a byte (DUT idle), check kick behaviour, wait for the pair.
  task automatic run_byte(input string tag, input logic [7:0] d, input bit kick,
                          input logic [7:0] exp_int);
    logic [7:0] exp_il;
    exp_il = kick ? ~d : d;
    sif.s_data  = d;
    sif.s_valid = 1'b1;
    tick();
    sif.s_valid = 1'b0;
    chk1({tag, "_sready_low"}, sif.s_ready, 1'b0);
    chk1({tag, "_busy"}, sif.busy, 1'b1);
    chk({tag, "_il_first"}, sif.il_data_in, exp_il);
    if (kick) begin
      tick();
      chk({tag, "_il_after_kick"}, sif.il_data_in, d);
    end
    wait_mvalid(tag);
    chk({tag, "_m_sys"}, sif.m_sys, d);
    chk({tag, "_m_int"}, sif.m_int, exp_int);
    chk({tag, "_m_int_vs_il"}, sif.m_int, sif.il_data_out);
  endtask

  task automatic consume(input string tag);
    sif.m_ready = 1'b1;
    tick();
    sif.m_ready = 1'b0;
    chk1({tag, "_mvalid_drop"}, sif.m_valid, 1'b0);
    chk1({tag, "_sready_back"}, sif.s_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_mvalid;
    sif.s_data  = 8'h00;
    sif.s_valid = 1'b0;
    sif.m_ready = 1'b0;
    sif.err_clr = 1'b0;
    tick();
    tick();
    chk1("rst_mvalid", sif.m_valid, 1'b0);
    chk("rst_m_sys", sif.m_sys, 8'h00);
    chk("rst_m_int", sif.m_int, 8'h00);
    chk("rst_il_data_in", sif.il_data_in, 8'h00);
    chk1("rst_timeout_err", sif.timeout_err, 1'b0);
    chk1("rst_sready", sif.s_ready, 1'b1);
    chk1("rst_busy", sif.busy, 1'b0);
    rst = 1'b0;
    tick();

    // First byte always kicks.
    run_byte("b3c", 8'h3C, 1'b1, 8'h3C);
    consume("b3c");

    // Back-to-back distinct bytes: no kick.
    run_byte("b12", 8'h12, 1'b0, 8'h21);
    consume("b12");
    run_byte("b34", 8'h34, 1'b0, 8'h38);

    // Downstream stall for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("hold_mvalid", sif.m_valid, 1'b1);
      chk("hold_m_sys", sif.m_sys, 8'h34);
      chk("hold_m_int", sif.m_int, 8'h38);
      chk1("hold_sready", sif.s_ready, 1'b0);
    end
    consume("b34");

    // Repeated byte: second one kicks.
    run_byte("b55a", 8'h55, 1'b0, 8'hAA);
    consume("b55a");
    run_byte("b55b", 8'h55, 1'b1, 8'hAA);
    consume("b55b");

    // Interleaver never drops enable: timeout after 64 wait cycles.
    stuck_en    = 1'b1;
    saw_mvalid  = 1'b0;
    sif.s_data  = 8'h5A;
    sif.s_valid = 1'b1;
    tick();
    sif.s_valid = 1'b0;
    chk("tmo_il", sif.il_data_in, 8'h5A);
    for (int i = 0; i < 63; i++) begin
      tick();
      if (sif.m_valid) saw_mvalid = 1'b1;
    end
    chk1("tmo_busy_before", sif.busy, 1'b1);
    chk1("tmo_err_before", sif.timeout_err, 1'b0);
    tick();
    if (sif.m_valid) saw_mvalid = 1'b1;
    chk1("tmo_err_set", sif.timeout_err, 1'b1);
    chk1("tmo_idle", sif.s_ready, 1'b1);
    chk1("tmo_no_mvalid", saw_mvalid, 1'b0);
    stuck_en = 1'b0;
    tick();

    // After a timeout the next byte kicks; error stays sticky.
    run_byte("b66", 8'h66, 1'b1, 8'h99);
    consume("b66");
    chk1("err_sticky", sif.timeout_err, 1'b1);
    sif.err_clr = 1'b1;
    tick();
    sif.err_clr = 1'b0;
    chk1("err_cleared", sif.timeout_err, 1'b0);

    // Reset during WAIT_DONE.
    sif.s_data  = 8'h77;
    sif.s_valid = 1'b1;
    tick();
    sif.s_valid = 1'b0;
    chk("b77_il", sif.il_data_in, 8'h77);
    tick();
    tick();
    tick();
    chk1("b77_busy_pre", sif.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_mvalid", sif.m_valid, 1'b0);
    chk1("midrst_busy", sif.busy, 1'b0);
    chk("midrst_il", sif.il_data_in, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    // Same byte after reset is treated as the first byte.
    run_byte("b77r", 8'h77, 1'b1, 8'hBB);
    consume("b77r");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
